mem_ctrl: RTL



---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_ctrl_if.sv | 27 ++
 rtl/mem_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// default RAM geometry and the wait-state counter width.
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

  function automatic logic addr_protected(input logic [31:0] addr, input logic [31:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Control-unit side request/response bundle of the memory access controller.
interface mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] mdr_out;
  logic [ADDR_W-1:0] mar_out;
  logic              prot_err;

  modport master (
    output req, we, addr_in, wdata_in,
    input  busy, done, mdr_out, mar_out, prot_err
  );

  modport slave (
    input  req, we, addr_in, wdata_in,
    output busy, done, mdr_out, mar_out, prot_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory access controller owning MAR/MDR, with programmable wait states.
// Optional write protection of the low address window: MEM_PROTECT_EN.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 1,
  parameter int PROT_LIMIT  = 128
) (
  input  logic              clk,
  input  logic              reset,
  mem_ctrl_if.slave         bus,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam logic HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : {WAIT_CNT_W{1'b0}};
`ifdef MEM_PROTECT_EN
  localparam logic PROT_ON = 1'b1;
`else
  localparam logic PROT_ON = 1'b0;
`endif

  mem_state_e              state_r, state_s;
  logic [ADDR_W-1:0]       mar_r, mar_s;
  logic [DATA_W-1:0]       mdr_r, mdr_s;
  logic                    we_r, we_s;
  logic [WAIT_CNT_W-1:0]   cnt_r, cnt_s;
  logic                    prot_hit_s;
  logic                    addr_hi_unused_s;

  // Upper address bits alias silently onto the RAM.
  assign addr_hi_unused_s = ^bus.addr_in[DATA_W-1:ADDR_W];

  // Next-state, MAR/MDR capture and wait-counter update.
  always_comb begin
    state_s = state_r;
    mar_s   = mar_r;
    mdr_s   = mdr_r;
    we_s    = we_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          mar_s = bus.addr_in[ADDR_W-1:0];
          we_s  = bus.we;
          if (bus.we) begin
            mdr_s = bus.wdata_in;
          end else begin
            mdr_s = mdr_r;
          end
          if (HAS_WAIT) begin
            state_s = WAIT;
            cnt_s   = WAIT_INIT;
          end else begin
            state_s = ACCESS;
            cnt_s   = {WAIT_CNT_W{1'b0}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
          state_s = ACCESS;
        end else begin
          cnt_s = cnt_r - WAIT_CNT_W'(1);
        end
      end
      ACCESS: begin
        state_s = DONE;
        if (!we_r) begin
          mdr_s = ram_r_data;
        end else begin
          mdr_s = mdr_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      mar_r   <= {ADDR_W{1'b0}};
      mdr_r   <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
      cnt_r   <= {WAIT_CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      mar_r   <= mar_s;
      mdr_r   <= mdr_s;
      we_r    <= we_s;
      cnt_r   <= cnt_s;
    end
  end

  // Store strobe stays combinational so the RAM samples it at the ACCESS exit edge.
  assign prot_hit_s   = PROT_ON & addr_protected(32'(mar_r), 32'(PROT_LIMIT));
  assign ram_wr_en    = (state_r == ACCESS) && we_r && !prot_hit_s;
  assign bus.prot_err = (state_r == ACCESS) && we_r && prot_hit_s;
  assign bus.busy     = (state_r != IDLE);
  assign bus.done     = (state_r == DONE);
  assign bus.mar_out  = mar_r;
  assign bus.mdr_out  = mdr_r;
  assign ram_r_addr   = mar_r;
  assign ram_w_addr   = mar_r;
  assign ram_w_data   = mdr_r;

endmodule
